charram_dram_ctrl: RTL and testbench

//  Timing generator/arbiter directly upstream of the 4416 char-RAM DRAM model. Multiplexes video fetches,
//  CPU read/write and RAS-only refresh onto one DRAM port: drives row/column address, /RAS, /CAS, /RD, /WR and DIN,
//  and captures DOUT. 14-bit linear address = {col[5:0], row[7:0]}. Column is presented on DRAM addr bits [6:1].

---
 rtl/charram_dram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_charram_dram_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/charram_dram_ctrl.sv
// charram_dram_ctrl
// Timing generator and arbiter for the 4416 character-RAM DRAM port.
// Video fetches, CPU reads/writes and RAS-only refresh share one DRAM port.
// The 14-bit linear address is {col[5:0], row[7:0]}.
// The column is driven on DRAM address bits [6:1].
module charram_dram_ctrl #(
    parameter int REFRESH_INTERVAL = 64
) (
    input  logic        i_MCLK,
    input  logic        i_RST,
    input  logic        i_VID_REQ,
    input  logic [13:0] i_VID_ADDR,
    output logic        o_VID_ACK,
    output logic [3:0]  o_VID_DATA,
    output logic        o_VID_VALID,
    input  logic        i_CPU_CS_n,
    input  logic        i_CPU_WR,
    input  logic [13:0] i_CPU_ADDR,
    input  logic [3:0]  i_CPU_DIN,
    output logic [3:0]  o_CPU_DOUT,
    output logic        o_CPU_DTACK_n,
    output logic [7:0]  o_DRAM_ADDR,
    output logic [3:0]  o_DRAM_DIN,
    input  logic [3:0]  i_DRAM_DOUT,
    output logic        o_RAS_n,
    output logic        o_CAS_n,
    output logic        o_RD_n,
    output logic        o_WR_n
);

    localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(REFRESH_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ROW, S_COL, S_ACC, S_CAPT, S_PRE, S_RHOLD
    } state_t;

    typedef enum logic [1:0] {
        OP_VID, OP_RD, OP_WR, OP_REF
    } op_t;

    state_t          state_q;
    op_t             op_q;
    logic [5:0]      col_q;
    logic [TW-1:0]   ref_tmr_q, ref_tmr_d;
    logic            ref_wrap;
    logic [7:0]      ref_row_q;
    logic            ref_pend_q;

    logic            vid_ack_q, vid_valid_q, dtack_n_q;
    logic [3:0]      vid_data_q, cpu_dout_q, dram_din_q;
    logic [7:0]      dram_addr_q;
    logic            ras_n_q, cas_n_q, rd_n_q, wr_n_q;

    assign o_VID_ACK     = vid_ack_q;
    assign o_VID_VALID   = vid_valid_q;
    assign o_VID_DATA    = vid_data_q;
    assign o_CPU_DOUT    = cpu_dout_q;
    assign o_CPU_DTACK_n = dtack_n_q;
    assign o_DRAM_ADDR   = dram_addr_q;
    assign o_DRAM_DIN    = dram_din_q;
    assign o_RAS_n       = ras_n_q;
    assign o_CAS_n       = cas_n_q;
    assign o_RD_n        = rd_n_q;
    assign o_WR_n        = wr_n_q;

    // Refresh timer next state: free-running, wraps at the end of each interval
    always_comb begin
        ref_wrap  = (ref_tmr_q == TMR_LAST);
        ref_tmr_d = ref_wrap ? '0 : ref_tmr_q + 1'b1;
    end

    // Refresh timer register
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) ref_tmr_q <= '0;
        else       ref_tmr_q <= ref_tmr_d;
    end

    // Arbiter and access sequencer; all DRAM and client outputs are registered here
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= S_IDLE;
            op_q        <= OP_VID;
            col_q       <= '0;
            ref_row_q   <= '0;
            ref_pend_q  <= 1'b0;
            vid_ack_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            dtack_n_q   <= 1'b1;
            vid_data_q  <= '0;
            cpu_dout_q  <= '0;
            dram_din_q  <= '0;
            dram_addr_q <= '0;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
        end else begin
            vid_ack_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            if (i_CPU_CS_n) dtack_n_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (i_VID_REQ) begin
                        op_q        <= OP_VID;
                        dram_addr_q <= i_VID_ADDR[7:0];
                        col_q       <= i_VID_ADDR[13:8];
                        ras_n_q     <= 1'b0;
                        vid_ack_q   <= 1'b1;
                        state_q     <= S_ROW;
                    end else if (ref_pend_q) begin
                        op_q        <= OP_REF;
                        dram_addr_q <= ref_row_q;
                        ras_n_q     <= 1'b0;
                        state_q     <= S_ROW;
                    end else if (!i_CPU_CS_n && dtack_n_q) begin
                        op_q        <= i_CPU_WR ? OP_WR : OP_RD;
                        dram_addr_q <= i_CPU_ADDR[7:0];
                        col_q       <= i_CPU_ADDR[13:8];
                        if (i_CPU_WR) dram_din_q <= i_CPU_DIN;
                        ras_n_q     <= 1'b0;
                        state_q     <= S_ROW;
                    end
                end
                S_ROW: begin
                    if (op_q == OP_REF) begin
                        state_q <= S_RHOLD;
                    end else begin
                        dram_addr_q <= {1'b0, col_q, 1'b0};
                        cas_n_q     <= 1'b0;
                        state_q     <= S_COL;
                    end
                end
                S_COL: begin
                    if (op_q == OP_WR) wr_n_q <= 1'b0;
                    else               rd_n_q <= 1'b0;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    rd_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                    state_q <= S_CAPT;
                end
                S_CAPT: begin
                    case (op_q)
                        OP_VID: begin
                            vid_data_q  <= i_DRAM_DOUT;
                            vid_valid_q <= 1'b1;
                        end
                        OP_RD: begin
                            cpu_dout_q <= i_DRAM_DOUT;
                            dtack_n_q  <= 1'b0;
                        end
                        default: dtack_n_q <= 1'b0;
                    endcase
                    ras_n_q <= 1'b1;
                    cas_n_q <= 1'b1;
                    state_q <= S_PRE;
                end
                S_RHOLD: begin
                    ras_n_q    <= 1'b1;
                    ref_row_q  <= ref_row_q + 1'b1;
                    ref_pend_q <= 1'b0;
                    state_q    <= S_PRE;
                end
                S_PRE:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            // A new interval tick takes precedence over the clear on refresh completion
            if (ref_wrap) ref_pend_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_charram_dram_ctrl.sv
// tb_charram_dram_ctrl
// Scoreboarded bench for charram_dram_ctrl with a behavioural 4416 DRAM model,
// directed timing scenarios and a randomized mixed video/CPU traffic phase.
module tb_charram_dram_ctrl;

    localparam int RI = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vreq = 1'b0;
    logic [13:0] vaddr = '0;
    logic        cs_n = 1'b1;
    logic        cwr = 1'b0;
    logic [13:0] caddr = '0;
    logic [3:0]  cdin = '0;
    logic [3:0]  dram_dout = '0;

    logic        o_VID_ACK, o_VID_VALID, o_CPU_DTACK_n;
    logic [3:0]  o_VID_DATA, o_CPU_DOUT, o_DRAM_DIN;
    logic [7:0]  o_DRAM_ADDR;
    logic        o_RAS_n, o_CAS_n, o_RD_n, o_WR_n;

    always #5 clk = ~clk;

    charram_dram_ctrl #(.REFRESH_INTERVAL(RI)) dut (
        .i_MCLK(clk), .i_RST(rst),
        .i_VID_REQ(vreq), .i_VID_ADDR(vaddr), .o_VID_ACK(o_VID_ACK),
        .o_VID_DATA(o_VID_DATA), .o_VID_VALID(o_VID_VALID),
        .i_CPU_CS_n(cs_n), .i_CPU_WR(cwr), .i_CPU_ADDR(caddr), .i_CPU_DIN(cdin),
        .o_CPU_DOUT(o_CPU_DOUT), .o_CPU_DTACK_n(o_CPU_DTACK_n),
        .o_DRAM_ADDR(o_DRAM_ADDR), .o_DRAM_DIN(o_DRAM_DIN), .i_DRAM_DOUT(dram_dout),
        .o_RAS_n(o_RAS_n), .o_CAS_n(o_CAS_n), .o_RD_n(o_RD_n), .o_WR_n(o_WR_n)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] mem[16384];
    logic [3:0] shadow[16384];

    typedef struct {
        logic       rd;
        logic [3:0] d;
    } cpu_t;

    logic [3:0] vid_q[$];
    cpu_t       cpu_q[$];

    function automatic logic [3:0] pat(input int a);
        int t;
        t = a ^ (a >> 4) ^ (a >> 9) ^ 5;
        return t[3:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural DRAM: latches row on /RAS fall, column on /CAS fall,
    // registered read data, write on sampled /WR; classifies RAS-only cycles as refresh
    logic [7:0] row_l = '0;
    logic [5:0] col_l = '0;
    logic       ras_p = 1'b1, cas_p = 1'b1, cas_seen = 1'b0;
    logic [7:0] ref_row_exp = '0;
    int         ref_cnt = 0, acc_cnt = 0;

    initial forever begin
        @(posedge clk);
        if (!o_RAS_n && ras_p) begin row_l = o_DRAM_ADDR; cas_seen = 1'b0; end
        if (!o_CAS_n && cas_p) begin col_l = o_DRAM_ADDR[6:1]; cas_seen = 1'b1; end
        if (!o_RD_n) dram_dout <= mem[{col_l, row_l}];
        if (!o_WR_n) mem[{col_l, row_l}] = o_DRAM_DIN;
        if (o_RAS_n && !ras_p) begin
            if (cas_seen) acc_cnt++;
            else begin
                chk("refresh_row", {24'd0, row_l}, {24'd0, ref_row_exp});
                ref_row_exp = ref_row_exp + 8'd1;
                ref_cnt++;
            end
        end
        if (rst) ref_row_exp = '0;
        ras_p = o_RAS_n;
        cas_p = o_CAS_n;
    end

    // Output monitor: pops the scoreboard on every data-bearing event
    logic dtack_prev = 1'b1;
    initial forever begin
        @(posedge clk);
        #1;
        if (o_VID_VALID) begin
            if (vid_q.size() == 0) chk("vid_unexpected_valid", 1, 0);
            else chk("vid_data", {28'd0, o_VID_DATA}, {28'd0, vid_q.pop_front()});
        end
        if (!o_CPU_DTACK_n && dtack_prev) begin
            if (cpu_q.size() == 0) chk("cpu_unexpected_dtack", 1, 0);
            else begin
                cpu_t e;
                e = cpu_q.pop_front();
                if (e.rd) chk("cpu_read_data", {28'd0, o_CPU_DOUT}, {28'd0, e.d});
            end
        end
        dtack_prev = o_CPU_DTACK_n;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic vid_access(input logic [13:0] a);
        int n;
        vid_q.push_back(shadow[a]);
        @(negedge clk);
        vreq  = 1'b1;
        vaddr = a;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!o_VID_ACK && n < 50);
        if (!o_VID_ACK) chk("vid_ack_timeout", 1, 0);
        vreq = 1'b0;
    endtask

    task automatic cpu_access(input logic wr, input logic [13:0] a, input logic [3:0] d,
                              input int hold, output int lat,
                              output logic [7:0] ra, output logic [7:0] ca);
        cpu_t e;
        e.rd = !wr;
        e.d  = wr ? d : shadow[a];
        cpu_q.push_back(e);
        if (wr) shadow[a] = d;
        @(negedge clk);
        cs_n = 1'b0; cwr = wr; caddr = a; cdin = d;
        lat = 0; ra = '0; ca = '0;
        do begin
            @(posedge clk); #1; lat++;
            if (lat == 1) ra = o_DRAM_ADDR;
            if (lat == 2) ca = o_DRAM_ADDR;
        end while (o_CPU_DTACK_n && lat < 400);
        if (o_CPU_DTACK_n) chk("cpu_dtack_timeout", 1, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("cpu_dtack_hold", {31'd0, o_CPU_DTACK_n}, 0);
        end
        @(negedge clk);
        cs_n = 1'b1;
        @(posedge clk); #1;
        chk("cpu_dtack_release", {31'd0, o_CPU_DTACK_n}, 1);
    endtask

    int         lat, n, base, ack_n, val_n, dt_n;
    logic [7:0] ra, ca, rra, rca;
    int         rlat;

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]    = pat(i);
            shadow[i] = pat(i);
        end

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ras", {31'd0, o_RAS_n}, 1);
        chk("rst_cas", {31'd0, o_CAS_n}, 1);
        chk("rst_rd", {31'd0, o_RD_n}, 1);
        chk("rst_wr", {31'd0, o_WR_n}, 1);
        chk("rst_dtack", {31'd0, o_CPU_DTACK_n}, 1);
        chk("rst_ack", {31'd0, o_VID_ACK}, 0);
        chk("rst_valid", {31'd0, o_VID_VALID}, 0);
        chk("rst_vdata", {28'd0, o_VID_DATA}, 0);
        chk("rst_cdout", {28'd0, o_CPU_DOUT}, 0);
        chk("rst_addr", {24'd0, o_DRAM_ADDR}, 0);
        chk("rst_din", {28'd0, o_DRAM_DIN}, 0);
        rst = 1'b0;

        // Idle after reset: first RAS-only refresh after a full interval, then the next row
        base = ref_cnt;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (o_RAS_n && n < 200);
        chk("t1_first_refresh_cycle", n, RI + 1);
        chk("t1_refresh_addr", {24'd0, o_DRAM_ADDR}, 0);
        chk("t1_refresh_cas", {31'd0, o_CAS_n}, 1);
        n = 0;
        while (ref_cnt < base + 2 && n < 150) begin @(posedge clk); n++; end
        chk("t1_two_refreshes", ref_cnt - base, 2);

        // CPU write then read of one location, latency and address phases
        do_reset();
        cpu_access(1'b1, 14'h2A5C, 4'h9, 0, lat, ra, ca);
        chk("t2_wr_latency", lat, 5);
        chk("t2_wr_row", {24'd0, ra}, 32'h5C);
        chk("t2_wr_col", {24'd0, ca}, 32'h54);
        cpu_access(1'b0, 14'h2A5C, 4'h0, 0, lat, ra, ca);
        chk("t2_rd_latency", lat, 5);
        chk("t2_rd_row", {24'd0, ra}, 32'h5C);
        chk("t2_rd_col", {24'd0, ca}, 32'h54);

        // Video and CPU requesting in the same cycle: video first
        do_reset();
        begin
            cpu_t e;
            vid_q.push_back(shadow[1]);
            e.rd = 1'b1;
            e.d  = shadow[14'h1234];
            cpu_q.push_back(e);
        end
        @(negedge clk);
        vreq = 1'b1; vaddr = 14'h0001;
        cs_n = 1'b0; cwr = 1'b0; caddr = 14'h1234;
        n = 0; ack_n = 0; val_n = 0; dt_n = 0;
        while (n < 40 && dt_n == 0) begin
            @(posedge clk); #1; n++;
            if (o_VID_ACK && ack_n == 0) begin ack_n = n; vreq = 1'b0; end
            if (o_VID_VALID) val_n = n;
            if (!o_CPU_DTACK_n) dt_n = n;
        end
        vreq = 1'b0;
        chk("t3_vid_ack_cycle", ack_n, 1);
        chk("t3_vid_valid_cycle", val_n, 5);
        chk("t3_cpu_dtack_cycle", dt_n, 11);
        @(negedge clk);
        cs_n = 1'b1;
        @(posedge clk); #1;
        chk("t3_dtack_release", {31'd0, o_CPU_DTACK_n}, 1);

        // Refresh pending and CPU pending together: refresh goes first
        do_reset();
        base = ref_cnt;
        repeat (RI) @(posedge clk);
        cpu_access(1'b0, 14'h0F0F, 4'h0, 0, lat, ra, ca);
        chk("t4_cpu_after_refresh_latency", lat, 9);
        chk("t4_one_refresh", ref_cnt - base, 1);

        // Refresh starved by continuous video across two intervals: one refresh afterwards
        do_reset();
        base = ref_cnt;
        for (int i = 0; i < 25; i++) vid_access(14'($urandom_range(0, 8191)));
        chk("t4_starved_no_refresh", ref_cnt - base, 0);
        repeat (20) @(posedge clk);
        chk("t4_single_refresh_after_starve", ref_cnt - base, 1);

        // Reset asserted during the write strobe aborts the access
        do_reset();
        @(negedge clk);
        cs_n = 1'b0; cwr = 1'b1; caddr = 14'h3001; cdin = ~shadow[14'h3001];
        n = 0;
        do begin @(posedge clk); #1; n++; end while (o_WR_n && n < 20);
        chk("t5_wr_strobe_cycle", n, 3);
        #2 rst = 1'b1;
        #1;
        chk("t5_abort_ras", {31'd0, o_RAS_n}, 1);
        chk("t5_abort_cas", {31'd0, o_CAS_n}, 1);
        chk("t5_abort_wr", {31'd0, o_WR_n}, 1);
        chk("t5_abort_rd", {31'd0, o_RD_n}, 1);
        cs_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_no_dtack", {31'd0, o_CPU_DTACK_n}, 1);
        rst = 1'b0;
        cpu_access(1'b0, 14'h3001, 4'h0, 0, rlat, rra, rca);
        chk("t5_idle_after_release", rlat, 5);

        // CS held low long after DTACK: exactly one access
        do_reset();
        base = acc_cnt;
        cpu_access(1'b0, 14'h2A5C, 4'h0, 10, lat, ra, ca);
        repeat (4) @(posedge clk);
        chk("t6_single_access", acc_cnt - base, 1);

        // Randomized concurrent video and CPU traffic with background refresh
        fork
            begin
                int       l;
                logic [7:0] r, c;
                logic     w;
                logic [13:0] a;
                for (int i = 0; i < 40; i++) begin
                    w = 1'($urandom_range(0, 1));
                    a = w ? {1'b1, 13'($urandom)} : 14'($urandom);
                    cpu_access(w, a, 4'($urandom), $urandom_range(0, 2), l, r, c);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    vid_access(14'($urandom_range(0, 8191)));
                end
            end
        join

        repeat (20) @(posedge clk);
        chk("vid_queue_drained", vid_q.size(), 0);
        chk("cpu_queue_drained", cpu_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
